// File: rtl/muxn_reg_if.sv
// N-channel mux bus: per-channel valid/ready inputs plus a registered output handshake.
// The sel_err flag exists only when MUXN_REG_SEL_ERR_EN is defined.
interface muxn_reg_if #(
  parameter int unsigned WL = 32,
  parameter int unsigned N  = 4
);
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  logic [SW-1:0]   mux_sel;
  logic [N*WL-1:0] din;
  logic [N-1:0]    din_valid;
  logic [N-1:0]    din_ready;
  logic [WL-1:0]   dout;
  logic            dout_valid;
  logic            dout_ready;
  logic [SW-1:0]   dout_src;
`ifdef MUXN_REG_SEL_ERR_EN
  logic            sel_err;

  modport master (output mux_sel, din, din_valid, dout_ready,
                  input  din_ready, dout, dout_valid, dout_src, sel_err);
  modport slave  (input  mux_sel, din, din_valid, dout_ready,
                  output din_ready, dout, dout_valid, dout_src, sel_err);
`else
  modport master (output mux_sel, din, din_valid, dout_ready,
                  input  din_ready, dout, dout_valid, dout_src);
  modport slave  (input  mux_sel, din, din_valid, dout_ready,
                  output din_ready, dout, dout_valid, dout_src);
`endif
endinterface

// File: rtl/muxn_reg.sv
// N-to-1 valid/ready mux with a single output register; explicit select (MODE 0) or round-robin (MODE 1).
// Optional out-of-range select flag enabled by MUXN_REG_SEL_ERR_EN.
module muxn_reg #(
  parameter int unsigned WL   = 32,
  parameter int unsigned N    = 4,
  parameter int unsigned MODE = 0
) (
  input logic     clk,
  input logic     rst,
  muxn_reg_if.slave bus
);
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  logic [WL-1:0] dout_q;
  logic [SW-1:0] src_q;
  logic          valid_q;
  logic [SW-1:0] rr_ptr;

  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic [WL-1:0] sel_word;
  logic          sel_valid;
  logic          load_ok;
  logic          xfer;

  // Grant: explicit select, or first valid channel scanning upward from rr_ptr with wrap.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (MODE == 0) begin
      if (32'(bus.mux_sel) < N) begin
        grant_valid = 1'b1;
        grant_idx   = bus.mux_sel;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!grant_valid && bus.din_valid[SW'((32'(rr_ptr) + k) % N)]) begin
          grant_valid = 1'b1;
          grant_idx   = SW'((32'(rr_ptr) + k) % N);
        end
      end
    end
  end

  // Pick the granted channel's word and valid.
  always_comb begin
    sel_word  = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_valid && (grant_idx == SW'(i))) begin
        sel_word  = bus.din[i*WL +: WL];
        sel_valid = bus.din_valid[i];
      end
    end
  end

  assign load_ok       = !valid_q || bus.dout_ready;
  assign xfer          = !rst && load_ok && grant_valid && sel_valid;
  assign bus.din_ready = (!rst && load_ok && grant_valid) ? (N'(1) << grant_idx) : '0;

  assign bus.dout       = dout_q;
  assign bus.dout_src   = src_q;
  assign bus.dout_valid = valid_q;

  // Output register: load on transfer, clear valid on take, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
    end else if (xfer) begin
      dout_q  <= sel_word;
      src_q   <= grant_idx;
      valid_q <= 1'b1;
    end else if (bus.dout_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the channel that transferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if ((MODE == 1) && xfer) begin
      rr_ptr <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
    end
  end

`ifdef MUXN_REG_SEL_ERR_EN
  logic sel_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= (MODE == 0) && load_ok && (32'(bus.mux_sel) >= N);
    end
  end

  assign bus.sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_muxn_reg.sv
// Bench for muxn_reg: three instances (MODE 0 N=4, MODE 1 N=4, MODE 0 N=3) against a behavioural model,
// with a directed vector table, hand-written corner sequences and a random phase.
module tb_muxn_reg;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  sel  [3];
  logic [31:0] wd   [3][4];
  logic [3:0]  vld  [3];
  logic        drdy [3];

  logic [3:0]  a_rdy  [3];
  logic [31:0] a_dout [3];
  logic [1:0]  a_src  [3];
  logic        a_vld  [3];
  logic        a_err  [3];
  logic [3:0]  pre_rdy[3];

  muxn_reg_if #(.WL(32), .N(4)) if0 ();
  muxn_reg_if #(.WL(32), .N(4)) if1 ();
  muxn_reg_if #(.WL(32), .N(3)) if2 ();

  muxn_reg #(.WL(32), .N(4), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  muxn_reg #(.WL(32), .N(4), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  muxn_reg #(.WL(32), .N(3), .MODE(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.mux_sel = sel[0];  assign if1.mux_sel = sel[1];  assign if2.mux_sel = sel[2];
  assign if0.din = {wd[0][3], wd[0][2], wd[0][1], wd[0][0]};
  assign if1.din = {wd[1][3], wd[1][2], wd[1][1], wd[1][0]};
  assign if2.din = {wd[2][2], wd[2][1], wd[2][0]};
  assign if0.din_valid = vld[0];  assign if1.din_valid = vld[1];  assign if2.din_valid = vld[2][2:0];
  assign if0.dout_ready = drdy[0]; assign if1.dout_ready = drdy[1]; assign if2.dout_ready = drdy[2];

  assign a_rdy[0] = if0.din_ready; assign a_rdy[1] = if1.din_ready; assign a_rdy[2] = {1'b0, if2.din_ready};
  assign a_dout[0] = if0.dout; assign a_dout[1] = if1.dout; assign a_dout[2] = if2.dout;
  assign a_src[0] = if0.dout_src; assign a_src[1] = if1.dout_src; assign a_src[2] = if2.dout_src;
  assign a_vld[0] = if0.dout_valid; assign a_vld[1] = if1.dout_valid; assign a_vld[2] = if2.dout_valid;
`ifdef MUXN_REG_SEL_ERR_EN
  assign a_err[0] = if0.sel_err; assign a_err[1] = if1.sel_err; assign a_err[2] = if2.sel_err;
`else
  assign a_err[0] = 1'b0; assign a_err[1] = 1'b0; assign a_err[2] = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: the held output word and the round-robin start channel.
  logic [31:0] m_dout [3];
  int          m_src  [3];
  bit          m_vld  [3];
  int          m_rr   [3];
  bit          m_err  [3];

  function automatic int nch(int k);  return (k == 2) ? 3 : 4; endfunction
  function automatic int mode(int k); return (k == 1) ? 1 : 0; endfunction

  function automatic int mgrant(int k);
    if (mode(k) == 0) return (int'(sel[k]) < nch(k)) ? int'(sel[k]) : -1;
    for (int off = 0; off < nch(k); off++) begin
      int c = (m_rr[k] + off) % nch(k);
      if (vld[k][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int k);
    int g = mgrant(k);
    if (rst || (m_vld[k] && !drdy[k]) || g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int g   = mgrant(k);
      bit lok = !m_vld[k] || drdy[k];
      bit xf  = !rst && lok && (g >= 0) && vld[k][g];
      if (rst) begin
        m_dout[k] = '0; m_src[k] = 0; m_vld[k] = 0; m_rr[k] = 0; m_err[k] = 0;
      end else begin
        m_err[k] = (mode(k) == 0) && lok && (int'(sel[k]) >= nch(k));
        if (xf) begin
          m_dout[k] = wd[k][g]; m_src[k] = g; m_vld[k] = 1;
          if (mode(k) == 1) m_rr[k] = (g + 1) % nch(k);
        end else if (drdy[k]) begin
          m_vld[k] = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: ready checked mid-cycle, registered outputs checked just after the edge.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pre_rdy[k] = a_rdy[k];
      check($sformatf("m%0d_din_ready", k), 64'(a_rdy[k]), 64'(exp_ready(k)));
    end
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("m%0d_dout", k), 64'(a_dout[k]), 64'(m_dout[k]));
      check($sformatf("m%0d_src", k), 64'(a_src[k]), 64'(m_src[k]));
      check($sformatf("m%0d_valid", k), 64'(a_vld[k]), 64'(m_vld[k]));
`ifdef MUXN_REG_SEL_ERR_EN
      check($sformatf("m%0d_sel_err", k), 64'(a_err[k]), 64'(m_err[k]));
`endif
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      sel[k] = 2'd0; vld[k] = 4'b0000; drdy[k] = 1'b1;
      for (int c = 0; c < 4; c++) wd[k][c] = $urandom;
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  v;
    logic [31:0] w;
    logic        dr;
    logic [3:0]  e_rdy;
    logic [31:0] e_dout;
    logic [1:0]  e_src;
    logic        e_vld;
  } vec_t;

  vec_t tbl[10];
  int   exp_rr_src[5];

  initial begin
    // Explicit-select vectors on instance 0; channel c carries w + c.
    tbl[0] = '{2'd2, 4'b0100, 32'hDEADBEED, 1'b1, 4'b0100, 32'hDEADBEEF, 2'd2, 1'b1};
    tbl[1] = '{2'd1, 4'b0010, 32'h10,       1'b0, 4'b0000, 32'hDEADBEEF, 2'd2, 1'b1};
    tbl[2] = '{2'd1, 4'b0010, 32'h10,       1'b0, 4'b0000, 32'hDEADBEEF, 2'd2, 1'b1};
    tbl[3] = '{2'd1, 4'b0010, 32'h10,       1'b0, 4'b0000, 32'hDEADBEEF, 2'd2, 1'b1};
    tbl[4] = '{2'd1, 4'b0010, 32'h10,       1'b1, 4'b0010, 32'h11,       2'd1, 1'b1};
    tbl[5] = '{2'd0, 4'b0000, 32'h0,        1'b1, 4'b0001, 32'h11,       2'd1, 1'b0};
    tbl[6] = '{2'd3, 4'b1000, 32'h100,      1'b0, 4'b1000, 32'h103,      2'd3, 1'b1};
    tbl[7] = '{2'd3, 4'b1000, 32'h200,      1'b1, 4'b1000, 32'h203,      2'd3, 1'b1};
    tbl[8] = '{2'd0, 4'b1111, 32'h300,      1'b1, 4'b0001, 32'h300,      2'd0, 1'b1};
    tbl[9] = '{2'd2, 4'b1011, 32'h400,      1'b1, 4'b0100, 32'h300,      2'd0, 1'b0};
    exp_rr_src = '{0, 1, 2, 3, 0};

    for (int k = 0; k < 3; k++) begin
      m_dout[k] = '1; m_src[k] = 3; m_vld[k] = 1; m_rr[k] = 0; m_err[k] = 1;
    end
    idle();
    rst = 1'b1;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_ready", k), 64'(pre_rdy[k]), 64'd0);
      check($sformatf("rst%0d_dout", k), 64'(a_dout[k]), 64'd0);
      check($sformatf("rst%0d_src", k), 64'(a_src[k]), 64'd0);
      check($sformatf("rst%0d_valid", k), 64'(a_vld[k]), 64'd0);
      check($sformatf("rst%0d_sel_err", k), 64'(a_err[k]), 64'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      sel[0] = tbl[i].sel; vld[0] = tbl[i].v; drdy[0] = tbl[i].dr;
      for (int c = 0; c < 4; c++) wd[0][c] = tbl[i].w + 32'(c);
      step();
      check($sformatf("tbl%0d_ready", i), 64'(pre_rdy[0]), 64'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_dout", i), 64'(a_dout[0]), 64'(tbl[i].e_dout));
      check($sformatf("tbl%0d_src", i), 64'(a_src[0]), 64'(tbl[i].e_src));
      check($sformatf("tbl%0d_valid", i), 64'(a_vld[0]), 64'(tbl[i].e_vld));
    end

    // Round-robin rotation from a fresh pointer with all channels valid.
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vld[1] = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) check("rr_first_ready", 64'(pre_rdy[1]), 64'b0001);
      check($sformatf("rr_src%0d", i), 64'(a_src[1]), 64'(exp_rr_src[i]));
      check($sformatf("rr_valid%0d", i), 64'(a_vld[1]), 64'd1);
    end
    // Move pointer to 3, then a lone ch1 request must wrap.
    vld[1] = 4'b0100;
    step();
    check("rr_to3_src", 64'(a_src[1]), 64'd2);
    vld[1] = 4'b0010;
    step();
    check("rr_wrap_ready", 64'(pre_rdy[1]), 64'b0010);
    check("rr_wrap_src", 64'(a_src[1]), 64'd1);
    vld[1] = 4'b1111;
    step();
    check("rr_after_wrap_ready", 64'(pre_rdy[1]), 64'b0100);
    check("rr_after_wrap_src", 64'(a_src[1]), 64'd2);

    // Out-of-range select on the 3-channel instance.
    idle();
    step();
    sel[2] = 2'd3; vld[2] = 4'b0111;
    step();
    check("oor_ready", 64'(pre_rdy[2]), 64'd0);
    check("oor_valid", 64'(a_vld[2]), 64'd0);
`ifdef MUXN_REG_SEL_ERR_EN
    check("oor_sel_err", 64'(a_err[2]), 64'd1);
`endif
    sel[2] = 2'd0; vld[2] = 4'b0000;
    step();
    check("oor_clear_ready", 64'(pre_rdy[2]), 64'b0001);
`ifdef MUXN_REG_SEL_ERR_EN
    check("oor_sel_err_pulse", 64'(a_err[2]), 64'd0);
`endif

    // Reset discards a held, untaken word.
    idle();
    sel[0] = 2'd2; vld[0] = 4'b0100; wd[0][2] = 32'hA5; drdy[0] = 1'b0;
    step();
    check("rstw_loaded_dout", 64'(a_dout[0]), 64'hA5);
    check("rstw_loaded_valid", 64'(a_vld[0]), 64'd1);
    rst = 1'b1;
    step();
    check("rstw_ready", 64'(pre_rdy[0]), 64'd0);
    check("rstw_dout", 64'(a_dout[0]), 64'd0);
    check("rstw_src", 64'(a_src[0]), 64'd0);
    check("rstw_valid", 64'(a_vld[0]), 64'd0);
    rst = 1'b0; vld[0] = 4'b0000; drdy[0] = 1'b1;
    step();
    check("rstw_after_valid", 64'(a_vld[0]), 64'd0);

    // Random traffic against the model on all instances.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < 3; k++) begin
        sel[k]  = 2'($urandom_range(0, 3));
        vld[k]  = 4'($urandom);
        drdy[k] = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < 4; c++) wd[k][c] = $urandom;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
